// File: rtl/axi_dram_responder.sv
// AXI4 slave memory responder: byte-enabled BRAM of 2**MEM_WORDS_LOG2 DATA_WID-bit words with
// independent single-outstanding read and write burst engines (INCR/FIXED).
module axi_dram_responder #(
   parameter int unsigned DATA_WID       = 512,
   parameter int unsigned ADDR_WID       = 32,
   parameter int unsigned ID_WID         = 5,
   parameter int unsigned MEM_WORDS_LOG2 = 10
) (
   input  logic                    mem_clk,
   input  logic                    mem_reset,
   input  logic [ADDR_WID-1:0]     s_awaddr,
   input  logic [ID_WID-1:0]       s_awid,
   input  logic [7:0]              s_awlen,
   input  logic [2:0]              s_awsize,
   input  logic [1:0]              s_awburst,
   input  logic                    s_awvalid,
   output logic                    s_awready,
   input  logic [DATA_WID-1:0]     s_wdata,
   input  logic [DATA_WID/8-1:0]   s_wstrb,
   input  logic                    s_wlast,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   output logic [ID_WID-1:0]       s_bid,
   output logic [1:0]              s_bresp,
   output logic                    s_bvalid,
   input  logic                    s_bready,
   input  logic [ADDR_WID-1:0]     s_araddr,
   input  logic [ID_WID-1:0]       s_arid,
   input  logic [7:0]              s_arlen,
   input  logic [2:0]              s_arsize,
   input  logic [1:0]              s_arburst,
   input  logic                    s_arvalid,
   output logic                    s_arready,
   output logic [DATA_WID-1:0]     s_rdata,
   output logic [ID_WID-1:0]       s_rid,
   output logic [1:0]              s_rresp,
   output logic                    s_rlast,
   output logic                    s_rvalid,
   input  logic                    s_rready
);

   localparam int unsigned STRB_WID = DATA_WID / 8;
   localparam int unsigned IDX_WID  = MEM_WORDS_LOG2;
   localparam int unsigned DEPTH    = 2 ** MEM_WORDS_LOG2;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

   // Out-of-range address beats a bad size/burst; evaluated once at address accept.
   function automatic logic [1:0] accept_err(input logic [ADDR_WID-1:0] addr,
                                             input logic [2:0] size, input logic [1:0] burst);
      if ((addr >> (MEM_WORDS_LOG2 + 6)) != '0) return RESP_DECERR;
      if (size != 3'd6 || burst[1]) return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

   logic [DATA_WID-1:0] mem [DEPTH];

   w_state_t           w_state;
   logic [IDX_WID-1:0] w_idx;
   logic [7:0]         w_len;
   logic [7:0]         w_cnt;
   logic               w_fixed;
   logic [1:0]         w_err;
   logic               w_mm;

   r_state_t           r_state;
   logic [IDX_WID-1:0] r_idx;
   logic [7:0]         r_len;
   logic [7:0]         r_cnt;
   logic               r_fixed;
   logic [1:0]         r_err;

   logic w_beat;
   logic w_last_beat;
   logic w_mm_now;
   logic mem_we;

   assign w_beat      = (w_state == W_DATA) && s_wvalid && s_wready;
   assign w_last_beat = (w_cnt == w_len);
   assign w_mm_now    = (s_wlast != w_last_beat);
   assign mem_we      = w_beat && (w_err == RESP_OKAY);

   // BRAM write port; no reset so contents survive mem_reset.
   always_ff @(posedge mem_clk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_WID; b++) begin
            if (s_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_wdata[b*8 +: 8];
         end
      end
   end

   // Write burst engine.
   always_ff @(posedge mem_clk or posedge mem_reset) begin
      if (mem_reset) begin
         w_state   <= W_IDLE;
         w_idx     <= '0;
         w_len     <= '0;
         w_cnt     <= '0;
         w_fixed   <= 1'b0;
         w_err     <= RESP_OKAY;
         w_mm      <= 1'b0;
         s_awready <= 1'b0;
         s_wready  <= 1'b0;
         s_bvalid  <= 1'b0;
         s_bid     <= '0;
         s_bresp   <= RESP_OKAY;
      end else begin
         case (w_state)
            W_IDLE: begin
               s_awready <= 1'b1;
               if (s_awvalid && s_awready) begin
                  s_awready <= 1'b0;
                  s_wready  <= 1'b1;
                  s_bid     <= s_awid;
                  w_idx     <= s_awaddr[MEM_WORDS_LOG2+5:6];
                  w_len     <= s_awlen;
                  w_cnt     <= '0;
                  w_fixed   <= (s_awburst == 2'b00);
                  w_err     <= accept_err(s_awaddr, s_awsize, s_awburst);
                  w_mm      <= 1'b0;
                  w_state   <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_beat) begin
                  w_cnt <= w_cnt + 8'd1;
                  if (!w_fixed) w_idx <= w_idx + IDX_WID'(1);
                  if (w_mm_now) w_mm <= 1'b1;
                  if (w_last_beat) begin
                     s_wready <= 1'b0;
                     s_bvalid <= 1'b1;
                     if (w_err == RESP_DECERR)
                        s_bresp <= RESP_DECERR;
                     else if (w_err == RESP_SLVERR || w_mm || w_mm_now)
                        s_bresp <= RESP_SLVERR;
                     else
                        s_bresp <= RESP_OKAY;
                     w_state <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (s_bready) begin
                  s_bvalid  <= 1'b0;
                  s_awready <= 1'b1;
                  w_state   <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read burst engine: one fetch cycle then one presentation cycle per beat.
   always_ff @(posedge mem_clk or posedge mem_reset) begin
      if (mem_reset) begin
         r_state   <= R_IDLE;
         r_idx     <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_fixed   <= 1'b0;
         r_err     <= RESP_OKAY;
         s_arready <= 1'b0;
         s_rvalid  <= 1'b0;
         s_rlast   <= 1'b0;
         s_rresp   <= RESP_OKAY;
         s_rid     <= '0;
         s_rdata   <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               s_arready <= 1'b1;
               if (s_arvalid && s_arready) begin
                  s_arready <= 1'b0;
                  s_rid     <= s_arid;
                  r_idx     <= s_araddr[MEM_WORDS_LOG2+5:6];
                  r_len     <= s_arlen;
                  r_cnt     <= '0;
                  r_fixed   <= (s_arburst == 2'b00);
                  r_err     <= accept_err(s_araddr, s_arsize, s_arburst);
                  r_state   <= R_FETCH;
               end
            end
            R_FETCH: begin
               s_rdata  <= (r_err == RESP_OKAY) ? mem[r_idx] : '0;
               s_rresp  <= r_err;
               s_rlast  <= (r_cnt == r_len);
               s_rvalid <= 1'b1;
               r_state  <= R_DATA;
            end
            R_DATA: begin
               if (s_rready) begin
                  s_rvalid <= 1'b0;
                  s_rlast  <= 1'b0;
                  if (s_rlast) begin
                     s_arready <= 1'b1;
                     r_state   <= R_IDLE;
                  end else begin
                     r_cnt   <= r_cnt + 8'd1;
                     if (!r_fixed) r_idx <= r_idx + IDX_WID'(1);
                     r_state <= R_FETCH;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_dram_responder.sv
// Self-checking bench for axi_dram_responder: vector table of bursts checked against a
// reference memory through B/R scoreboards, plus stall and mid-burst reset sequences.
module tb_axi_dram_responder;

   localparam int unsigned DW    = 512;
   localparam int unsigned AW    = 32;
   localparam int unsigned IW    = 5;
   localparam int unsigned SW    = DW / 8;
   localparam int unsigned DEPTH = 1024;
   localparam int          TMO   = 100;

   logic          mem_clk = 1'b0;
   logic          mem_reset = 1'b1;
   logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
   logic [IW-1:0] s_awid = '0, s_arid = '0;
   logic [7:0]    s_awlen = '0, s_arlen = '0;
   logic [2:0]    s_awsize = 3'd6, s_arsize = 3'd6;
   logic [1:0]    s_awburst = 2'b01, s_arburst = 2'b01;
   logic          s_awvalid = 1'b0, s_arvalid = 1'b0;
   logic          s_awready, s_arready;
   logic [DW-1:0] s_wdata = '0;
   logic [SW-1:0] s_wstrb = '0;
   logic          s_wlast = 1'b0, s_wvalid = 1'b0, s_wready;
   logic [IW-1:0] s_bid, s_rid;
   logic [1:0]    s_bresp, s_rresp;
   logic          s_bvalid, s_bready = 1'b1;
   logic [DW-1:0] s_rdata;
   logic          s_rlast, s_rvalid, s_rready = 1'b0;

   always #5 mem_clk = ~mem_clk;

   axi_dram_responder #(.DATA_WID(DW), .ADDR_WID(AW), .ID_WID(IW), .MEM_WORDS_LOG2(10)) dut (
      .mem_clk(mem_clk), .mem_reset(mem_reset),
      .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize),
      .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
      .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
      .s_bready(s_bready), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
      .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [4:0]  id;
      logic [7:0]  len;
      logic [1:0]  burst;
      logic [2:0]  size;
      logic [63:0] strb;
      logic [7:0]  seed;
      bit          fill;
      int          wlast_beat;
      int          stall;
      logic [1:0]  exp_resp;
   } vec_t;

   typedef struct { logic [DW-1:0] data; logic [1:0] resp; logic last; logic [IW-1:0] id; } rbeat_t;
   typedef struct { logic [IW-1:0] id; logic [1:0] resp; } bresp_t;

   logic [DW-1:0] model [DEPTH];
   rbeat_t        r_q[$];
   bresp_t        b_q[$];
   vec_t          vecs[$];
   int            n_checks = 0;
   int            n_fail = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout, got no handshake expected one within %0d cycles", name, TMO);
   endtask

   task automatic tick();
      @(posedge mem_clk);
      #1;
   endtask

   function automatic logic [DW-1:0] make_data(input logic [7:0] seed, input int k, input bit fill);
      logic [DW-1:0] d;
      for (int j = 0; j < SW; j++) d[j*8 +: 8] = fill ? 8'hAA : 8'(int'(seed) + k * 37 + j);
      return d;
   endfunction

   function automatic logic [1:0] acc_err(input logic [31:0] addr, input logic [2:0] size,
                                          input logic [1:0] burst);
      if (addr >= 32'h0001_0000) return 2'b11;
      if (size != 3'd6 || !(burst == 2'b00 || burst == 2'b01)) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [9:0] word_of(input vec_t v, input int k);
      return (v.burst == 2'b00) ? v.addr[15:6] : 10'(int'(v.addr[15:6]) + k);
   endfunction

   function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [4:0] id,
                               input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size,
                               input logic [63:0] strb, input logic [7:0] seed, input bit fill,
                               input int wlast_beat, input int stall, input logic [1:0] exp_resp);
      return '{wr, addr, id, len, burst, size, strb, seed, fill, wlast_beat, stall, exp_resp};
   endfunction

   task automatic do_write(input vec_t v);
      int t;
      logic [DW-1:0] d;
      bresp_t e;
      s_awaddr = v.addr; s_awid = v.id; s_awlen = v.len;
      s_awsize = v.size; s_awburst = v.burst; s_awvalid = 1'b1;
      t = 0;
      while (!s_awready && t < TMO) begin tick(); t++; end
      if (t == TMO) timeout("aw_handshake");
      tick();
      s_awvalid = 1'b0;
      b_q.push_back('{v.id, v.exp_resp});
      for (int k = 0; k <= int'(v.len); k++) begin
         d = make_data(v.seed, k, v.fill);
         s_wdata = d; s_wstrb = v.strb; s_wvalid = 1'b1;
         s_wlast = (v.wlast_beat < 0) ? (k == int'(v.len)) : (k == v.wlast_beat);
         t = 0;
         while (!s_wready && t < TMO) begin tick(); t++; end
         if (t == TMO) timeout("w_handshake");
         tick();
         if (acc_err(v.addr, v.size, v.burst) == 2'b00)
            for (int j = 0; j < SW; j++)
               if (v.strb[j]) model[word_of(v, k)][j*8 +: 8] = d[j*8 +: 8];
      end
      s_wvalid = 1'b0; s_wlast = 1'b0;
      t = 0;
      while (!s_bvalid && t < TMO) begin tick(); t++; end
      if (t == TMO) timeout("b_valid");
      e = b_q.pop_front();
      check("bid", DW'(s_bid), DW'(e.id));
      check("bresp", DW'(s_bresp), DW'(e.resp));
      tick();
   endtask

   task automatic do_read(input vec_t v);
      int t;
      rbeat_t e;
      for (int k = 0; k <= int'(v.len); k++)
         r_q.push_back('{(v.exp_resp == 2'b00) ? model[word_of(v, k)] : '0,
                        v.exp_resp, (k == int'(v.len)), v.id});
      s_araddr = v.addr; s_arid = v.id; s_arlen = v.len;
      s_arsize = v.size; s_arburst = v.burst; s_arvalid = 1'b1;
      t = 0;
      while (!s_arready && t < TMO) begin tick(); t++; end
      if (t == TMO) timeout("ar_handshake");
      tick();
      s_arvalid = 1'b0;
      for (int k = 0; k <= int'(v.len); k++) begin
         t = 0;
         while (!s_rvalid && t < TMO) begin tick(); t++; end
         if (t == TMO) timeout("r_valid");
         if (k == 0) begin
            for (int s = 0; s < v.stall; s++) begin
               tick();
               check("stall_rvalid", DW'(s_rvalid), DW'(1'b1));
               check("stall_rdata", s_rdata, r_q[0].data);
               check("stall_rlast", DW'(s_rlast), DW'(r_q[0].last));
            end
         end
         e = r_q.pop_front();
         check("rdata", s_rdata, e.data);
         check("rresp", DW'(s_rresp), DW'(e.resp));
         check("rlast", DW'(s_rlast), DW'(e.last));
         check("rid", DW'(s_rid), DW'(e.id));
         s_rready = 1'b1;
         tick();
         s_rready = 1'b0;
      end
   endtask

   initial begin
      int t;
      rbeat_t e;
      vec_t v;
      localparam logic [63:0] ALL = '1;

      // Reset state
      #12;
      check("rst_awready", DW'(s_awready), DW'(1'b0));
      check("rst_arready", DW'(s_arready), DW'(1'b0));
      check("rst_wready", DW'(s_wready), DW'(1'b0));
      check("rst_bvalid", DW'(s_bvalid), DW'(1'b0));
      check("rst_rvalid", DW'(s_rvalid), DW'(1'b0));
      check("rst_rlast", DW'(s_rlast), DW'(1'b0));
      check("rst_rdata", s_rdata, '0);
      check("rst_ids", DW'({s_bid, s_rid, s_bresp, s_rresp}), '0);
      @(negedge mem_clk);
      mem_reset = 1'b0;
      #1;
      check("awready_before_edge", DW'(s_awready), DW'(1'b0));
      tick();
      check("awready_after_release", DW'(s_awready), DW'(1'b1));
      check("arready_after_release", DW'(s_arready), DW'(1'b1));

      vecs.push_back(mk(1, 32'h40,    5'd3,  8'd3, 2'b01, 3'd6, ALL,   8'h01, 0, -1, 0, 2'b00));
      vecs.push_back(mk(0, 32'h40,    5'd9,  8'd3, 2'b01, 3'd6, ALL,   8'h00, 0, -1, 0, 2'b00));
      vecs.push_back(mk(1, 32'h80,    5'd1,  8'd0, 2'b01, 3'd6, ALL,   8'h00, 1, -1, 0, 2'b00));
      vecs.push_back(mk(1, 32'h80,    5'd2,  8'd0, 2'b01, 3'd6, 64'hFF, 8'h20, 0, -1, 0, 2'b00));
      vecs.push_back(mk(0, 32'h80,    5'd4,  8'd0, 2'b01, 3'd6, ALL,   8'h00, 0, -1, 0, 2'b00));
      vecs.push_back(mk(1, 32'h0,     5'd5,  8'd0, 2'b01, 3'd6, ALL,   8'h50, 0, -1, 0, 2'b00));
      vecs.push_back(mk(1, 32'h10000, 5'd6,  8'd0, 2'b01, 3'd6, ALL,   8'h60, 0, -1, 0, 2'b11));
      vecs.push_back(mk(0, 32'h0,     5'd7,  8'd0, 2'b01, 3'd6, ALL,   8'h00, 0, -1, 0, 2'b00));
      vecs.push_back(mk(0, 32'h10000, 5'd8,  8'd0, 2'b01, 3'd6, ALL,   8'h00, 0, -1, 0, 2'b11));
      vecs.push_back(mk(1, 32'h100,   5'd11, 8'd1, 2'b01, 3'd5, ALL,   8'h33, 0, -1, 0, 2'b10));
      vecs.push_back(mk(0, 32'h100,   5'd12, 8'd1, 2'b10, 3'd6, ALL,   8'h00, 0, -1, 0, 2'b10));
      vecs.push_back(mk(1, 32'hFF80,  5'd13, 8'd3, 2'b01, 3'd6, ALL,   8'h70, 0, -1, 0, 2'b00));
      vecs.push_back(mk(0, 32'hFF80,  5'd14, 8'd3, 2'b01, 3'd6, ALL,   8'h00, 0, -1, 0, 2'b00));
      vecs.push_back(mk(0, 32'h0,     5'd15, 8'd1, 2'b01, 3'd6, ALL,   8'h00, 0, -1, 0, 2'b00));
      vecs.push_back(mk(1, 32'h140,   5'd16, 8'd3, 2'b00, 3'd6, ALL,   8'h90, 0, -1, 0, 2'b00));
      vecs.push_back(mk(0, 32'h140,   5'd17, 8'd2, 2'b00, 3'd6, ALL,   8'h00, 0, -1, 0, 2'b00));

      foreach (vecs[i]) begin
         if (vecs[i].wr) do_write(vecs[i]);
         else            do_read(vecs[i]);
      end

      // Early wlast, then a read whose first beat is back-pressured for 5 cycles
      do_write(mk(1, 32'h200, 5'd18, 8'd3, 2'b01, 3'd6, ALL, 8'hC0, 0, 1, 0, 2'b10));
      do_read(mk(0, 32'h200, 5'd19, 8'd3, 2'b01, 3'd6, ALL, 8'h00, 0, -1, 5, 2'b00));

      // Reset in the middle of a read burst
      v = mk(0, 32'h40, 5'd20, 8'd3, 2'b01, 3'd6, ALL, 8'h00, 0, -1, 0, 2'b00);
      s_araddr = v.addr; s_arid = v.id; s_arlen = v.len; s_arburst = v.burst; s_arsize = v.size;
      s_arvalid = 1'b1;
      t = 0;
      while (!s_arready && t < TMO) begin tick(); t++; end
      if (t == TMO) timeout("ar_rst_handshake");
      tick();
      s_arvalid = 1'b0;
      t = 0;
      while (!s_rvalid && t < TMO) begin tick(); t++; end
      if (t == TMO) timeout("r_rst_first");
      check("rst_burst_beat0", s_rdata, model[1]);
      s_rready = 1'b1;
      tick();
      s_rready = 1'b0;
      t = 0;
      while (!s_rvalid && t < TMO) begin tick(); t++; end
      if (t == TMO) timeout("r_rst_second");
      #2 mem_reset = 1'b1;
      #1;
      check("midrst_rvalid", DW'(s_rvalid), DW'(1'b0));
      check("midrst_arready", DW'(s_arready), DW'(1'b0));
      @(posedge mem_clk);
      @(posedge mem_clk);
      #3 mem_reset = 1'b0;
      #1;
      check("postrst_arready_low", DW'(s_arready), DW'(1'b0));
      tick();
      check("postrst_arready", DW'(s_arready), DW'(1'b1));
      check("postrst_rvalid", DW'(s_rvalid), DW'(1'b0));
      do_read(v);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
      $fatal(1, "watchdog");
   end

endmodule
